occ_rom_arbiter: RTL and testbench
==================================

// Module: occ_rom_arbiter
// PURPOSE
//  Shares the single read port of rom_Occ between two requesters (req0 = get_data_2
//  path, req1 = get_data_3 path, or any future Occ consumer). Round-robin
//  arbitration, valid/ready request handshake, fixed-latency ROM read tracked by a
//  tag pipeline, and a registered per-requester response. Replaces the state-decoded
//  ce/addr mux in accelerator_fsm once the Occ fetches overlap in time.
// PARAMETERS
//  ADDR_W   8   rom_Occ address width
//  DATA_W   32  rom_Occ data width
//  ROM_LAT  1   cycles from ce/addr to valid data_rom_Occ_i; legal 1..4
// PORTS
//  clk              in   1       clock, all logic on rising edge
//  rst_n            in   1       synchronous reset, active-low
//  req0_valid_i     in   1       requester 0 has a read pending
//  req0_addr_i      in   ADDR_W  requester 0 read address
//  req0_ready_o     out  1       requester 0 request accepted this cycle
//  rsp0_valid_o     out  1       one-cycle pulse: rsp0_data_o updated
//  rsp0_data_o      out  DATA_W  last data returned to requester 0 (held)
//  req1_valid_i     in   1       requester 1 has a read pending
//  req1_addr_i      in   ADDR_W  requester 1 read address
//  req1_ready_o     out  1       requester 1 request accepted this cycle
//  rsp1_valid_o     out  1       one-cycle pulse: rsp1_data_o updated
//  rsp1_data_o      out  DATA_W  last data returned to requester 1 (held)
//  ce_rom_Occ_o     out  1       rom_Occ chip enable
//  addr_rom_Occ_o   out  ADDR_W  rom_Occ address
//  data_rom_Occ_i   in   DATA_W  rom_Occ read data
//  busy_o           out  1       any request pending or read in flight
//  conflict_cnt_o   out  16      cycles with both requests valid, saturating
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): last_grant<=1 (req0 wins first tie), tag pipe
//    cleared, rsp*_valid_o=0, rsp*_data_o=0, conflict_cnt_o=0. Combinational
//    outputs follow from cleared state: with no valid input, ce=0, addr=0, ready=0.
//  - Arbitration, combinational each cycle: only one valid -> grant it; both valid
//    -> grant the requester not in last_grant; none -> no grant. Exactly one grant max.
//  - reqN_ready_o = grantN (same cycle). Transfer = valid & ready. Requester holds
//    valid and addr stable until ready; arbiter never samples addr without grant.
//  - ce_rom_Occ_o = any grant; addr_rom_Occ_o = granted addr, else 0.
//  - last_grant updates only on a grant. Throughput 1 read/cycle, no bubbles.
//  - Tag pipe: ROM_LAT stages of {vld, id}; stage0 loads {grant_any, grant_id}.
//    On output of last stage with vld: capture data_rom_Occ_i into rsp<id>_data_o
//    and pulse rsp<id>_valid_o next cycle. Latency accept -> rsp_valid = ROM_LAT+1.
//  - Responses return in acceptance order; each requester sees its own in order.
//  - rsp_data_o holds until that requester's next response; the other requester's
//    response never disturbs it.
//  - busy_o = req0_valid_i | req1_valid_i | any tag-pipe vld | any rsp_valid pending.
//  - conflict_cnt_o += 1 on each cycle with both valids; stops at 16'hFFFF.
//  - Reset mid-operation: in-flight tags dropped, no rsp_valid pulse in the cycle
//    after reset or for reads accepted before reset.
//  - Back-to-back same requester: allowed every cycle while the other is idle.
// TESTING
//  1 Reset then idle: all outputs 0, ce=0, busy=0, conflict_cnt=0 for 10 cycles.
//  2 req0 only, addr 8'h05 (ROM_LAT=1): ready0 same cycle, ce=1 addr=05,
//    rsp0_valid pulse 2 cycles later with ROM[05]; rsp1_valid stays 0.
//  3 Both valid 4 cycles, addr0=10, addr1=20: grants 0,1,0,1; rsp alternates
//    with ROM[10]/ROM[20]; conflict_cnt=3 (4th cycle: only req1 left valid).
//  4 req1 streams addrs 1..8 back-to-back, ROM_LAT=3: 8 rsp1 pulses, in order,
//    first at accept+4, no gaps; rsp0_data_o unchanged.
//  5 rst_n low one cycle with 2 reads in flight: no rsp_valid afterwards,
//    next tie grants req0.
//  6 Force 65540 conflict cycles: conflict_cnt_o saturates at 16'hFFFF.

Source files
------------

// File: rtl/occ_rom_arbiter.sv
// Round-robin arbiter sharing the single rom_Occ read port between two
// requesters. A {vld, id} tag pipeline tracks each read through the ROM's fixed
// latency, so returned data is steered to the requester that issued it.
module occ_rom_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    output logic              req0_ready_o,
    output logic              rsp0_valid_o,
    output logic [DATA_W-1:0] rsp0_data_o,
    input  logic              req1_valid_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    output logic              req1_ready_o,
    output logic              rsp1_valid_o,
    output logic [DATA_W-1:0] rsp1_data_o,
    output logic              ce_rom_Occ_o,
    output logic [ADDR_W-1:0] addr_rom_Occ_o,
    input  logic [DATA_W-1:0] data_rom_Occ_i,
    output logic              busy_o,
    output logic [15:0]       conflict_cnt_o
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Saturating increment for the conflict counter: sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        if (val == CNT_MAX) begin
            return CNT_MAX;
        end
        return val + 16'd1;
    endfunction

    logic               grant0;
    logic               grant1;
    logic               grant_any;
    logic               grant_id;
    logic               last_grant;
    logic               both_valid;
    logic [ROM_LAT-1:0] tag_vld_p;
    logic [ROM_LAT-1:0] tag_id_p;
    logic               tag_vld_last;
    logic               tag_id_last;

    assign both_valid = req0_valid_i & req1_valid_i;

    // Round-robin grant: on a tie the requester that did not win last time wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (both_valid) begin
            if (last_grant) begin
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
        end else if (req0_valid_i) begin
            grant0 = 1'b1;
        end else if (req1_valid_i) begin
            grant1 = 1'b1;
        end
    end

    assign grant_any      = grant0 | grant1;
    assign grant_id       = grant1;
    assign req0_ready_o   = grant0;
    assign req1_ready_o   = grant1;
    assign ce_rom_Occ_o   = grant_any;
    assign addr_rom_Occ_o = grant0 ? req0_addr_i :
                            grant1 ? req1_addr_i : '0;

    // Remember the last winner; reset value 1 lets req0 win the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (grant_any) begin
            last_grant <= grant_id;
        end
    end

    // --- stage p0..p(ROM_LAT-1): tag valid follows each read through the ROM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_vld_p <= '0;
        end else begin
            tag_vld_p[0] <= grant_any;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_vld_p[i] <= tag_vld_p[i-1];
            end
        end
    end

    // Tag id travels with its valid bit; only consumed when that bit is set.
    always_ff @(posedge clk) begin
        tag_id_p[0] <= grant_id;
        for (int i = 1; i < ROM_LAT; i++) begin
            tag_id_p[i] <= tag_id_p[i-1];
        end
    end

    assign tag_vld_last = tag_vld_p[ROM_LAT-1];
    assign tag_id_last  = tag_id_p[ROM_LAT-1];

    // --- response stage: steer ROM data to the owning requester, pulse valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp0_valid_o <= 1'b0;
            rsp1_valid_o <= 1'b0;
        end else begin
            rsp0_valid_o <= tag_vld_last & ~tag_id_last;
            rsp1_valid_o <= tag_vld_last & tag_id_last;
        end
    end

    // Response data holds until that requester's own next response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp0_data_o <= '0;
            rsp1_data_o <= '0;
        end else if (tag_vld_last) begin
            if (tag_id_last) begin
                rsp1_data_o <= data_rom_Occ_i;
            end else begin
                rsp0_data_o <= data_rom_Occ_i;
            end
        end
    end

    // Count cycles in which both requesters contend, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflict_cnt_o <= '0;
        end else if (both_valid) begin
            conflict_cnt_o <= sat_inc16(conflict_cnt_o);
        end
    end

    assign busy_o = req0_valid_i | req1_valid_i | (|tag_vld_p) |
                    rsp0_valid_o | rsp1_valid_o;

endmodule

// File: tb/tb_occ_rom_arbiter.sv
// Directed bench for occ_rom_arbiter: two instances share the request inputs,
// one with ROM_LAT=1 (dut_a) and one with ROM_LAT=3 (dut_b), each with its own
// ROM model whose read data is a fixed function of the address.
module tb_occ_rom_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic          req1_valid;
    logic [AW-1:0] req1_addr;

    logic          a_ready0, a_ready1, a_rsp0_valid, a_rsp1_valid, a_ce, a_busy;
    logic [DW-1:0] a_rsp0_data, a_rsp1_data, a_rom_q;
    logic [AW-1:0] a_rom_addr;
    logic [15:0]   a_cnt;

    logic          b_ready0, b_ready1, b_rsp0_valid, b_rsp1_valid, b_ce, b_busy;
    logic [DW-1:0] b_rsp0_data, b_rsp1_data;
    logic [DW-1:0] b_rom_q [3];
    logic [AW-1:0] b_rom_addr;
    logic [15:0]   b_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return {a, ~a, a ^ 8'h5A, a + 8'h33};
    endfunction

    // ROM models: one-cycle and three-cycle read latency.
    always_ff @(posedge clk) a_rom_q <= rom_word(a_rom_addr);

    always_ff @(posedge clk) begin
        b_rom_q[0] <= rom_word(b_rom_addr);
        b_rom_q[1] <= b_rom_q[0];
        b_rom_q[2] <= b_rom_q[1];
    end

    occ_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(req0_valid), .req0_addr_i(req0_addr), .req0_ready_o(a_ready0),
        .rsp0_valid_o(a_rsp0_valid), .rsp0_data_o(a_rsp0_data),
        .req1_valid_i(req1_valid), .req1_addr_i(req1_addr), .req1_ready_o(a_ready1),
        .rsp1_valid_o(a_rsp1_valid), .rsp1_data_o(a_rsp1_data),
        .ce_rom_Occ_o(a_ce), .addr_rom_Occ_o(a_rom_addr), .data_rom_Occ_i(a_rom_q),
        .busy_o(a_busy), .conflict_cnt_o(a_cnt)
    );

    occ_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(req0_valid), .req0_addr_i(req0_addr), .req0_ready_o(b_ready0),
        .rsp0_valid_o(b_rsp0_valid), .rsp0_data_o(b_rsp0_data),
        .req1_valid_i(req1_valid), .req1_addr_i(req1_addr), .req1_ready_o(b_ready1),
        .rsp1_valid_o(b_rsp1_valid), .rsp1_data_o(b_rsp1_data),
        .ce_rom_Occ_o(b_ce), .addr_rom_Occ_o(b_rom_addr), .data_rom_Occ_i(b_rom_q[2]),
        .busy_o(b_busy), .conflict_cnt_o(b_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input logic v0, input logic [AW-1:0] a0,
                           input logic v1, input logic [AW-1:0] a1);
        req0_valid = v0;
        req0_addr  = a0;
        req1_valid = v1;
        req1_addr  = a1;
    endtask

    // One reset cycle; returns on a falling edge with rst_n released.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_req(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_req(1'b0, '0, 1'b0, '0);

        // 1: reset then idle for 10 cycles
        do_reset();
        for (int k = 0; k < 10; k++) begin
            #1;
            check("idle_ctrl", {a_ready0, a_ready1, a_ce, a_rsp0_valid, a_rsp1_valid, a_busy}, '0);
            check("idle_addr_cnt", {a_rom_addr, a_cnt}, '0);
            check("idle_data", {a_rsp0_data, a_rsp1_data}, '0);
            @(negedge clk);
        end
        check("idle_b_ctrl", {b_ce, b_busy, b_cnt, b_rsp0_data}, '0);

        // 2: single req0 read of address 05, ROM_LAT=1
        do_reset();
        set_req(1'b1, 8'h05, 1'b0, '0);
        #1;
        check("t2_ready0", a_ready0, 1'b1);
        check("t2_ready1", a_ready1, 1'b0);
        check("t2_ce", a_ce, 1'b1);
        check("t2_addr", a_rom_addr, 8'h05);
        check("t2_busy", a_busy, 1'b1);
        @(negedge clk);
        set_req(1'b0, '0, 1'b0, '0);
        #1;
        check("t2_rsp0_early", a_rsp0_valid, 1'b0);
        @(negedge clk);
        #1;
        check("t2_rsp0_valid", a_rsp0_valid, 1'b1);
        check("t2_rsp0_data", a_rsp0_data, rom_word(8'h05));
        check("t2_rsp1_valid", a_rsp1_valid, 1'b0);
        @(negedge clk);
        #1;
        check("t2_rsp0_pulse_end", a_rsp0_valid, 1'b0);
        check("t2_rsp0_hold", a_rsp0_data, rom_word(8'h05));
        check("t2_busy_done", a_busy, 1'b0);

        // 3: contention, grants 0,1,0,1 and alternating responses
        do_reset();
        for (int k = 0; k < 6; k++) begin
            if (k < 3)       set_req(1'b1, 8'h10, 1'b1, 8'h20);
            else if (k == 3) set_req(1'b0, '0, 1'b1, 8'h20);
            else             set_req(1'b0, '0, 1'b0, '0);
            #1;
            if (k < 4) begin
                check("t3_ready0", a_ready0, (k % 2 == 0));
                check("t3_ready1", a_ready1, (k % 2 == 1));
                check("t3_addr", a_rom_addr, (k % 2 == 1) ? 8'h20 : 8'h10);
            end
            check("t3_rsp0_valid", a_rsp0_valid, (k == 2 || k == 4));
            check("t3_rsp1_valid", a_rsp1_valid, (k == 3 || k == 5));
            if (k == 4) check("t3_rsp0_data", a_rsp0_data, rom_word(8'h10));
            if (k == 5) check("t3_rsp1_data", a_rsp1_data, rom_word(8'h20));
            @(negedge clk);
        end
        #1;
        check("t3_conflict_cnt", a_cnt, 16'd3);

        // 4: req1 streams addresses 1..8, ROM_LAT=3; rsp0_data must not move
        do_reset();
        set_req(1'b1, 8'hA0, 1'b0, '0);
        @(negedge clk);
        set_req(1'b0, '0, 1'b0, '0);
        repeat (6) @(negedge clk);
        #1;
        check("t4_rsp0_pre", b_rsp0_data, rom_word(8'hA0));
        @(negedge clk);
        for (int k = 0; k < 13; k++) begin
            logic [AW-1:0] a;
            a = AW'(k + 1);
            if (k < 8) set_req(1'b0, '0, 1'b1, a);
            else       set_req(1'b0, '0, 1'b0, '0);
            #1;
            if (k < 8) check("t4_ready1", b_ready1, 1'b1);
            check("t4_rsp1_valid", b_rsp1_valid, (k >= 4 && k < 12));
            if (k >= 4 && k < 12) begin
                a = AW'(k - 3);
                check("t4_rsp1_data", b_rsp1_data, rom_word(a));
            end
            check("t4_rsp0_valid", b_rsp0_valid, 1'b0);
            @(negedge clk);
        end
        #1;
        check("t4_rsp0_hold", b_rsp0_data, rom_word(8'hA0));

        // 5: reset with two reads in flight, then tie goes to req0
        do_reset();
        set_req(1'b1, 8'h03, 1'b0, '0);
        @(negedge clk);
        set_req(1'b0, '0, 1'b1, 8'h04);
        @(negedge clk);
        rst_n = 1'b0;
        set_req(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t5_busy_b", b_busy, 1'b0);
        for (int k = 0; k < 6; k++) begin
            check("t5_no_rsp", {a_rsp0_valid, a_rsp1_valid, b_rsp0_valid, b_rsp1_valid}, '0);
            @(negedge clk);
            #1;
        end
        set_req(1'b1, 8'h07, 1'b1, 8'h08);
        #1;
        check("t5_tie_a", {a_ready0, a_ready1}, 2'b10);
        check("t5_tie_b", {b_ready0, b_ready1}, 2'b10);
        @(negedge clk);
        set_req(1'b0, '0, 1'b0, '0);

        // 6: conflict counter saturation
        do_reset();
        set_req(1'b1, 8'h01, 1'b1, 8'h02);
        for (int k = 1; k <= 65540; k++) begin
            @(negedge clk);
            if (k == 65534) begin
                #1;
                check("t6_cnt_near", a_cnt, 16'hFFFE);
            end
        end
        #1;
        check("t6_cnt_sat_a", a_cnt, 16'hFFFF);
        check("t6_cnt_sat_b", b_cnt, 16'hFFFF);
        check("t6_busy", a_busy, 1'b1);
        set_req(1'b0, '0, 1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
